irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Parametrised multi-line interrupt sequencer for the five-stage pipeline.
- Replaces the single-line int1/int2 pipeline chain with NUM_IRQ prioritised, maskable, vectored interrupt lines.
- Per request, the sequencer stalls fetch and drains the pipeline.
- It then pushes the resume PC and the CCR through the memory-stage push path, and redirects fetch to a per-line vector.
- Sits beside the fetch stage. Drives the PC-enable and jump-address muxes, and talks to the memory stage through a push request/ack handshake.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (1..16).
- PC_W, 32, PC width; must be a multiple of DATA_W.
- DATA_W, 16, stack word width.
- CCR_W, 3, flag register width (<= DATA_W).
- EDGE_MASK, all ones, per-line mode: 1 = rising-edge triggered, 0 = level.
- VEC_BASE, 0, vector address of line 0.
- VEC_STRIDE, 2, address step between consecutive vectors.
- DRAIN_CYCLES, 4, bubble cycles inserted before saving state (1..15).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- irq, in, NUM_IRQ, interrupt request lines.
- mask_we, in, 1, write enable for mask register.
- mask_wdata, in, NUM_IRQ, new mask (1 = line disabled).
- resume_pc, in, PC_W, address of the next unexecuted instruction.
- ccr_in, in, CCR_W, current flag register.
- reti, in, 1, one-cycle pulse when the ISR return (pop CCR + pop PC) retires in WB.
- push_ack, in, 1, memory stage accepted the current push word.
- stall_fetch, out, 1, hold PC and inject NOP into fetch/decode.
- push_req, out, 1, push request to memory stage.
- push_data, out, DATA_W, word to push.
- vector_valid, out, 1, one-cycle PC load strobe.
- vector_addr, out, PC_W, ISR address.
- irq_ack, out, NUM_IRQ, one-hot one-cycle acknowledge.
- int_active, out, 1, ISR in progress.
- pending, out, NUM_IRQ, pending latch state.

Behaviour:
- Reset (synchronous): state IDLE; pending, mask, and saved PC/CCR/id cleared. All outputs 0; vector_addr 0.
- Pending latch, edge line: set on a 0->1 transition of irq[i] (previous sample held in a register).
- Pending latch, level line: set while irq[i]=1.
- Pending clears only in VECTOR for the serviced line.
- If a set and a clear hit the same cycle, the set wins.
- Masked lines still latch pending but cannot trigger.
- Mask write takes effect next cycle. Any decision made in the same cycle uses the old mask.
- Priority: lowest index among pending & ~mask wins.
- States: IDLE, DRAIN, SAVE_PC, SAVE_CCR, VECTOR, IN_ISR.
- IDLE -> DRAIN when any unmasked line is pending. Capture id, resume_pc, and ccr_in that cycle, and load drain counter = DRAIN_CYCLES.
- stall_fetch = 1 from the next cycle through VECTOR inclusive.
- DRAIN: decrement the counter each cycle; at 1 -> SAVE_PC. Total DRAIN_CYCLES cycles in DRAIN.
- SAVE_PC: push PC_W/DATA_W words, most-significant word first.
  - push_req = 1 and push_data stable until push_ack.
  - Advance one word per acked cycle; after the last ack -> SAVE_CCR.
  - Without ack, hold indefinitely.
- SAVE_CCR: push_data = zero-extended saved CCR; push_req held until ack -> VECTOR.
- VECTOR: single cycle.
  - vector_valid = 1; vector_addr = VEC_BASE + id*VEC_STRIDE (PC_W arithmetic, wraps modulo 2^PC_W).
  - irq_ack[id] = 1; pending[id] cleared.
  - Next state IN_ISR.
- IN_ISR: int_active = 1, stall_fetch = 0. No nesting: new requests latch pending but are not taken. reti -> IDLE.
- Back in IDLE, a still-pending line triggers the next cycle (tail-chaining through the full sequence).
- reti in any state other than IN_ISR is ignored.
- Reset in any state aborts immediately: push_req drops the following cycle and no vector is issued.
- Worst-case entry latency, ack every cycle: 1 + DRAIN_CYCLES + PC_W/DATA_W + 1 + 1 cycles to vector_valid. Defaults give 9.

Test Plan:
- Defaults: irq[2] rises at cycle 0, push_ack tied 1, resume_pc=0x0000_1234, ccr_in=3'b101.
  - stall_fetch rises at cycle 1.
  - Pushes 0x0000, 0x1234, 0x0005.
  - vector_valid at cycle 8 with vector_addr=4; irq_ack=4'b0100.
- irq[0] and irq[3] rise together -> line 0 serviced first (vector 0). After reti, line 3 is serviced (vector 6) with no re-assertion.
- mask_wdata=4'b0001, irq[0] pulse -> pending[0]=1, no stall. Unmask -> sequence starts the cycle after the mask write.
- push_ack held 0 for 5 cycles during SAVE_PC -> push_data stays 0x0000 with push_req=1 throughout. No advance until ack.
- irq[1] during IN_ISR -> no stall, pending[1]=1. reti -> re-entry, vector 2.
- reset asserted in SAVE_CCR -> next cycle all outputs 0, state IDLE, pending 0. A later reti is ignored.

Source files
------------

// File: rtl/irq_sequencer.sv
// Prioritised, maskable, vectored interrupt sequencer: drains the pipeline, pushes PC then CCR, redirects fetch.
// Latency: request to vector_valid is 1 + DRAIN_CYCLES + PC_W/DATA_W + 1 + 1 cycles when push_ack is high every cycle.
// Backpressure: push_req/push_data hold until push_ack; the sequence waits indefinitely for the memory stage.
module irq_sequencer #(
    parameter int                  NUM_IRQ      = 4,
    parameter int                  PC_W         = 32,
    parameter int                  DATA_W       = 16,
    parameter int                  CCR_W        = 3,
    parameter logic [NUM_IRQ-1:0]  EDGE_MASK    = '1,
    parameter logic [PC_W-1:0]     VEC_BASE     = '0,
    parameter logic [PC_W-1:0]     VEC_STRIDE   = PC_W'(2),
    parameter int                  DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    input  logic [PC_W-1:0]     resume_pc,
    input  logic [CCR_W-1:0]    ccr_in,
    input  logic                reti,
    input  logic                push_ack,
    output logic                stall_fetch,
    output logic                push_req,
    output logic [DATA_W-1:0]   push_data,
    output logic                vector_valid,
    output logic [PC_W-1:0]     vector_addr,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic                int_active,
    output logic [NUM_IRQ-1:0]  pending
);

    localparam int          NWORDS         = PC_W / DATA_W;
    localparam int          ID_W           = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int          WCNT_W         = $clog2(NWORDS + 1);
    localparam logic [3:0]  DRAIN_CNT_INIT = 4'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE_PC,
        SAVE_CCR,
        VECTOR,
        IN_ISR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  pending_q;
    logic [NUM_IRQ-1:0]  mask_q;
    logic [NUM_IRQ-1:0]  set_vec;
    logic [NUM_IRQ-1:0]  cand;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     id_q;
    logic [PC_W-1:0]     pc_q;
    logic [CCR_W-1:0]    ccr_q;
    logic [3:0]          drain_cnt;
    logic [WCNT_W-1:0]   word_cnt;

    // Edge lines compare against last cycle's sample; level lines set whenever high.
    assign set_vec = (irq & ~irq_q & EDGE_MASK) | (irq & ~EDGE_MASK);
    // Same-cycle sets are eligible so entry costs only one IDLE cycle; the mask is the registered (old) one.
    assign cand    = (pending_q | set_vec) & ~mask_q;
    assign pending = pending_q;

    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (|cand) state_nxt = DRAIN;
            DRAIN:    if (drain_cnt == 4'd1) state_nxt = SAVE_PC;
            SAVE_PC:  if (push_ack && (word_cnt == WCNT_W'(NWORDS - 1))) state_nxt = SAVE_CCR;
            SAVE_CCR: if (push_ack) state_nxt = VECTOR;
            VECTOR:   state_nxt = IN_ISR;
            IN_ISR:   if (reti) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_fetch  = 1'b0;
        push_req     = 1'b0;
        push_data    = '0;
        vector_valid = 1'b0;
        vector_addr  = '0;
        irq_ack      = '0;
        int_active   = 1'b0;
        case (state)
            DRAIN: begin
                stall_fetch = 1'b1;
            end
            SAVE_PC: begin
                stall_fetch = 1'b1;
                push_req    = 1'b1;
                push_data   = pc_q[PC_W-1 -: DATA_W];
            end
            SAVE_CCR: begin
                stall_fetch = 1'b1;
                push_req    = 1'b1;
                push_data   = DATA_W'(ccr_q);
            end
            VECTOR: begin
                stall_fetch  = 1'b1;
                vector_valid = 1'b1;
                vector_addr  = VEC_BASE + PC_W'(id_q) * VEC_STRIDE;
                irq_ack      = NUM_IRQ'(1) << id_q;
            end
            IN_ISR: begin
                int_active = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            id_q      <= '0;
            pc_q      <= '0;
            ccr_q     <= '0;
            drain_cnt <= '0;
            word_cnt  <= '0;
        end else begin
            irq_q     <= irq;
            // irq_ack doubles as the clear vector; OR-ing set last lets a same-cycle set win.
            pending_q <= (pending_q & ~irq_ack) | set_vec;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            case (state)
                IDLE: begin
                    if (|cand) begin
                        id_q      <= win_id;
                        pc_q      <= resume_pc;
                        ccr_q     <= ccr_in;
                        drain_cnt <= DRAIN_CNT_INIT;
                        word_cnt  <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 4'd1;
                end
                SAVE_PC: begin
                    // Shift so the word on push_data is always the top slice, most-significant first.
                    if (push_ack) begin
                        pc_q     <= pc_q << DATA_W;
                        word_cnt <= word_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Randomised and directed bench for irq_sequencer with a phase-level reference model and push/vector scoreboard.
module tb_irq_sequencer;

    localparam int N      = 4;
    localparam int PC_W   = 32;
    localparam int DATA_W = 16;
    localparam int CCR_W  = 3;
    localparam int DR     = 4;
    localparam int NW     = PC_W / DATA_W;
    localparam logic [N-1:0] EM = '1;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      irq;
    logic              mask_we;
    logic [N-1:0]      mask_wdata;
    logic [PC_W-1:0]   resume_pc;
    logic [CCR_W-1:0]  ccr_in;
    logic              reti;
    logic              push_ack;
    logic              stall_fetch;
    logic              push_req;
    logic [DATA_W-1:0] push_data;
    logic              vector_valid;
    logic [PC_W-1:0]   vector_addr;
    logic [N-1:0]      irq_ack;
    logic              int_active;
    logic [N-1:0]      pending;

    always #5 clk = ~clk;

    irq_sequencer dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .resume_pc(resume_pc), .ccr_in(ccr_in), .reti(reti), .push_ack(push_ack),
        .stall_fetch(stall_fetch), .push_req(push_req), .push_data(push_data),
        .vector_valid(vector_valid), .vector_addr(vector_addr), .irq_ack(irq_ack),
        .int_active(int_active), .pending(pending)
    );

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases of one interrupt entry, advanced from the inputs the bench drives.
    typedef enum {M_IDLE, M_DRAIN, M_SAVE, M_VEC, M_ISR} mph_t;
    mph_t              mph = M_IDLE;
    int                drain_left;
    int                acks_left;
    int                m_id;
    logic [N-1:0]      m_pend = '0;
    logic [N-1:0]      m_mask = '0;
    logic [N-1:0]      m_prev = '0;
    logic [DATA_W-1:0] exp_words[$];
    logic [PC_W-1:0]   exp_vaddr[$];
    logic [N-1:0]      exp_vack[$];

    always @(posedge clk) begin : model
        logic [N-1:0] set;
        logic [N-1:0] clr;
        logic [N-1:0] cand;
        if (reset) begin
            mph    = M_IDLE;
            m_pend = '0;
            m_mask = '0;
            m_prev = '0;
            exp_words.delete();
            exp_vaddr.delete();
            exp_vack.delete();
        end else begin
            set = (irq & ~m_prev & EM) | (irq & ~EM);
            clr = '0;
            case (mph)
                M_IDLE: begin
                    cand = (m_pend | set) & ~m_mask;
                    if (cand != '0) begin
                        m_id = 0;
                        while (!cand[m_id]) m_id++;
                        for (int w = NW - 1; w >= 0; w--) exp_words.push_back(resume_pc[w*DATA_W +: DATA_W]);
                        exp_words.push_back(DATA_W'(ccr_in));
                        exp_vaddr.push_back(PC_W'(0 + m_id * 2));
                        exp_vack.push_back(N'(1) << m_id);
                        drain_left = DR;
                        acks_left  = NW + 1;
                        mph        = M_DRAIN;
                    end
                end
                M_DRAIN: begin
                    drain_left--;
                    if (drain_left == 0) mph = M_SAVE;
                end
                M_SAVE: begin
                    if (push_ack) begin
                        acks_left--;
                        if (acks_left == 0) mph = M_VEC;
                    end
                end
                M_VEC: begin
                    clr[m_id] = 1'b1;
                    mph = M_ISR;
                end
                M_ISR: if (reti) mph = M_IDLE;
                default: mph = M_IDLE;
            endcase
            m_pend = (m_pend & ~clr) | set;
            m_prev = irq;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    // Monitor: compares control outputs every cycle and pops the scoreboard on accepted pushes and vectors.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("stall_fetch", 64'(stall_fetch), 64'(mph inside {M_DRAIN, M_SAVE, M_VEC}));
            chk("int_active", 64'(int_active), 64'(mph == M_ISR));
            chk("push_req", 64'(push_req), 64'(mph == M_SAVE));
            chk("vector_valid", 64'(vector_valid), 64'(mph == M_VEC));
            chk("pending", 64'(pending), 64'(m_pend));
            if (push_req) begin
                chk("push_expected", 64'(exp_words.size() != 0), 64'd1);
                if (exp_words.size() != 0) begin
                    chk("push_data", 64'(push_data), 64'(exp_words[0]));
                    if (push_ack) void'(exp_words.pop_front());
                end
            end else begin
                chk("push_data_idle", 64'(push_data), 64'd0);
            end
            if (vector_valid) begin
                chk("vector_expected", 64'(exp_vaddr.size() != 0), 64'd1);
                if (exp_vaddr.size() != 0) begin
                    chk("vector_addr", 64'(vector_addr), 64'(exp_vaddr.pop_front()));
                    chk("irq_ack", 64'(irq_ack), 64'(exp_vack.pop_front()));
                end
            end else begin
                chk("irq_ack_idle", 64'(irq_ack), 64'd0);
                chk("vector_addr_idle", 64'(vector_addr), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vec(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vector_valid && n < 60);
        chk("vector_timeout", 64'(vector_valid), 64'd1);
    endtask

    task automatic finish_isr();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!int_active && n < 60);
        chk("int_active_timeout", 64'(int_active), 64'd1);
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
        resume_pc = '0; ccr_in = '0; reti = 1'b0; push_ack = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_stall", 64'(stall_fetch), 64'd0);
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_vaddr", 64'(vector_addr), 64'd0);
        tick();
        reset = 1'b0;
        mon_en = 1'b1;

        // Single request on line 2, ack every cycle.
        push_ack = 1'b1; resume_pc = 32'h0000_1234; ccr_in = 3'b101; irq = 4'b0100;
        @(negedge clk);
        chk("s1_stall_c0", 64'(stall_fetch), 64'd0);
        tick();
        irq = '0;
        @(negedge clk);
        chk("s1_stall_c1", 64'(stall_fetch), 64'd1);
        wait_vec(n);
        chk("s1_vec_cycle", 64'(1 + n), 64'd8);
        chk("s1_vec_addr", 64'(vector_addr), 64'd4);
        chk("s1_irq_ack", 64'(irq_ack), 64'b0100);
        finish_isr();

        // Lines 0 and 3 together: 0 first, then 3 tail-chains.
        irq = 4'b1001;
        tick();
        irq = '0;
        wait_vec(n);
        chk("s2_first_vec", 64'(vector_addr), 64'd0);
        finish_isr();
        wait_vec(n);
        chk("s2_second_vec", 64'(vector_addr), 64'd6);
        finish_isr();

        // Masked line latches pending without starting; unmask starts it.
        mask_we = 1'b1; mask_wdata = 4'b0001;
        tick();
        mask_we = 1'b0; irq = 4'b0001;
        tick();
        irq = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("s3_masked_pending", 64'(pending), 64'b0001);
        chk("s3_masked_nostall", 64'(stall_fetch), 64'd0);
        tick();
        mask_we = 1'b1; mask_wdata = '0;
        tick();
        mask_we = 1'b0;
        @(negedge clk);
        chk("s3_unmask_decide", 64'(stall_fetch), 64'd0);
        tick();
        @(negedge clk);
        chk("s3_unmask_stall", 64'(stall_fetch), 64'd1);
        wait_vec(n);
        chk("s3_vec", 64'(vector_addr), 64'd0);
        finish_isr();

        // Push backpressure during SAVE_PC.
        push_ack = 1'b0; resume_pc = 32'h5A5A_1234; irq = 4'b0010;
        tick();
        irq = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!push_req && n < 60);
        chk("s4_push_timeout", 64'(push_req), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("s4_hold_req", 64'(push_req), 64'd1);
            chk("s4_hold_data", 64'(push_data), 64'h5A5A);
        end
        tick();
        push_ack = 1'b1;
        wait_vec(n);
        chk("s4_vec", 64'(vector_addr), 64'd2);
        finish_isr();

        // Request during IN_ISR is held until reti.
        irq = 4'b0100;
        tick();
        irq = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!int_active && n < 60);
        chk("s5_active_timeout", 64'(int_active), 64'd1);
        tick();
        irq = 4'b0010;
        tick();
        irq = '0;
        @(negedge clk);
        chk("s5_no_nest", 64'(stall_fetch), 64'd0);
        chk("s5_pending", 64'(pending), 64'b0010);
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        wait_vec(n);
        chk("s5_reentry_vec", 64'(vector_addr), 64'd2);
        finish_isr();

        // Reset while pushing the CCR aborts the entry; later reti is ignored.
        ccr_in = 3'b101; irq = 4'b0001;
        tick();
        irq = '0;
        repeat (6) tick();
        @(negedge clk);
        chk("s6_in_save_ccr", 64'(push_data), 64'h0005);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("s6_abort_req", 64'(push_req), 64'd0);
        chk("s6_abort_vec", 64'(vector_valid), 64'd0);
        chk("s6_abort_stall", 64'(stall_fetch), 64'd0);
        chk("s6_abort_pending", 64'(pending), 64'd0);
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("s6_reti_ignored", 64'(int_active), 64'd0);
        tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            irq        = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            push_ack   = ($urandom_range(0, 3) != 0);
            resume_pc  = $urandom;
            ccr_in     = CCR_W'($urandom);
            mask_we    = ($urandom_range(0, 29) == 0);
            mask_wdata = N'($urandom);
            reti       = int_active ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            tick();
        end

        // Drain everything still pending.
        for (int c = 0; c < 300; c++) begin
            irq = '0; push_ack = 1'b1; reset = 1'b0;
            mask_we = (c == 0); mask_wdata = '0;
            reti = int_active;
            tick();
        end
        reti = 1'b0;
        @(negedge clk);
        chk("end_words_empty", 64'(exp_words.size()), 64'd0);
        chk("end_vectors_empty", 64'(exp_vaddr.size()), 64'd0);
        chk("end_pending_clear", 64'(pending), 64'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
